// File: rtl/arm_boot_ctrl.sv
// Boot-load sequencer for the arm core: receives a framed program over a byte stream,
// writes it into instruction memory, verifies an XOR checksum and then releases the core.
module arm_boot_ctrl #(
   parameter int             DEPTH     = 64,
   parameter int             ADDR_W    = 6,
   parameter logic [7:0]     SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_RUN, S_ERROR
   } state_t;

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   state_t            r_state;
   state_t            w_next;
   logic [7:0]        r_len_lo;
   logic [15:0]       r_len;
   logic [ADDR_W:0]   r_index;
   logic [1:0]        r_byte_cnt;
   logic [7:0]        r_csum;
   logic [23:0]       r_word;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_addr;
   logic [31:0]       r_imem_wdata;
   logic              r_cpu_reset;

   logic              w_accept;
   logic [15:0]       w_len;
   logic [ADDR_W:0]   w_index_inc;
   logic              w_last_word;

   assign rx_ready    = (r_state != S_WRITE);
   assign w_accept    = rx_valid && rx_ready;
   assign w_len       = {rx_data, r_len_lo};
   assign w_index_inc = r_index + 1'b1;
   assign w_last_word = (16'(w_index_inc) == r_len);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept && rx_data == SYNC_BYTE) w_next = S_LEN_LO;
         S_LEN_LO: if (w_accept) w_next = S_LEN_HI;
         S_LEN_HI: if (w_accept) begin
            if (w_len > DEPTH_W)   w_next = S_ERROR;
            else if (w_len == '0)  w_next = S_CSUM;
            else                   w_next = S_DATA;
         end
         S_DATA:   if (w_accept && r_byte_cnt == 2'd3) w_next = S_WRITE;
         S_WRITE:  w_next = w_last_word ? S_CSUM : S_DATA;
         S_CSUM:   if (w_accept) w_next = (rx_data == r_csum) ? S_RUN : S_ERROR;
         S_RUN, S_ERROR:
                   if (w_accept && rx_data == SYNC_BYTE) w_next = S_LEN_LO;
         default:  w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_len_lo     <= '0;
         r_len        <= '0;
         r_index      <= '0;
         r_byte_cnt   <= '0;
         r_csum       <= '0;
         r_word       <= '0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_cpu_reset  <= 1'b1;
      end else begin
         r_imem_we   <= 1'b0;
         r_cpu_reset <= (w_next != S_RUN);
         case (r_state)
            S_LEN_LO: if (w_accept) r_len_lo <= rx_data;
            S_LEN_HI: if (w_accept) begin
               r_len      <= w_len;
               r_index    <= '0;
               r_byte_cnt <= '0;
               r_csum     <= '0;
            end
            S_DATA: if (w_accept) begin
               r_csum     <= r_csum ^ rx_data;
               r_byte_cnt <= r_byte_cnt + 2'd1;
               case (r_byte_cnt)
                  2'd0: r_word[7:0]   <= rx_data;
                  2'd1: r_word[15:8]  <= rx_data;
                  2'd2: r_word[23:16] <= rx_data;
                  default: begin
                     // Final byte goes straight into the write word so the strobe lands in WRITE.
                     r_imem_we    <= 1'b1;
                     r_imem_addr  <= r_index[ADDR_W-1:0];
                     r_imem_wdata <= {rx_data, r_word};
                  end
               endcase
            end
            S_WRITE: r_index <= w_index_inc;
            default: ;
         endcase
      end
   end

   assign imem_we    = r_imem_we;
   assign imem_addr  = r_imem_addr;
   assign imem_wdata = r_imem_wdata;
   assign cpu_reset  = r_cpu_reset;
   assign busy       = (r_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM});
   assign done       = (r_state == S_RUN);
   assign err        = (r_state == S_ERROR);

endmodule

// File: tb/tb_arm_boot_ctrl.sv
// Randomized bench for arm_boot_ctrl: builds frames, predicts the writes and final status
// from the frame contents, and compares against what the controller does.
module tb_arm_boot_ctrl;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic              clk = 1'b0;
   logic              reset;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              err;

   arm_boot_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   int          checks = 0;
   int          errors = 0;
   int          ready_viol = 0;
   wr_t         wr_q[$];
   logic [31:0] exp_words[DEPTH];

   // Observed memory writes, and the rule that the byte port stalls exactly on write cycles.
   always @(negedge clk) begin
      wr_t w;
      if (imem_we === 1'b1) begin
         w.addr = imem_addr;
         w.data = imem_wdata;
         wr_q.push_back(w);
      end
      if (rx_ready === imem_we) ready_viol++;
   end

   function automatic logic [7:0] noise_byte();
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      return b;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard;
      if (gap > 0) begin
         rx_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      guard    = 0;
      while (rx_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_byte_stall: rx_ready stuck at %b, required 1", rx_ready);
      end
      @(negedge clk);
   endtask

   // Frame body after the sync byte; expected words come from exp_words[0..n-1].
   task automatic send_frame(input int n, input bit good, input bit gaps, input bit with_sync);
      logic [7:0]  csum;
      logic [15:0] len;
      logic [31:0] w;
      logic [7:0]  b;
      len  = 16'(n);
      csum = 8'h00;
      if (with_sync) send_byte(8'hA5, 0);
      send_byte(len[7:0], gaps ? int'($urandom_range(0, 2)) : 0);
      send_byte(len[15:8], gaps ? int'($urandom_range(0, 2)) : 0);
      for (int i = 0; i < n; i++) begin
         w = exp_words[i];
         for (int k = 0; k < 4; k++) begin
            b    = w[8*k +: 8];
            csum = csum ^ b;
            send_byte(b, gaps ? int'($urandom_range(0, 2)) : 0);
         end
      end
      if (!good) csum = csum ^ 8'($urandom_range(1, 255));
      send_byte(csum, gaps ? int'($urandom_range(0, 2)) : 0);
      rx_valid = 1'b0;
   endtask

   task automatic check_load(input string name, input int n, input bit good);
      checks++;
      if (wr_q.size() !== n) begin
         errors++;
         $display("FAIL %s write_count: got %0d, required %0d", name, wr_q.size(), n);
      end
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== exp_words[i]) begin
            errors++;
            $display("FAIL %s write[%0d]: got %h@%0d, required %h@%0d",
                     name, i, wr_q[i].data, wr_q[i].addr, exp_words[i], i);
         end
      end
      checks++;
      if ({busy, done, err, cpu_reset} !== {1'b0, good, !good, !good}) begin
         errors++;
         $display("FAIL %s status: got busy=%b done=%b err=%b cpu_reset=%b, required 0 %b %b %b",
                  name, busy, done, err, cpu_reset, good, !good, !good);
      end
      if (n > 0) begin
         checks++;
         if (imem_we !== 1'b0 || imem_addr !== ADDR_W'(n - 1) || imem_wdata !== exp_words[n-1]) begin
            errors++;
            $display("FAIL %s hold: got we=%b %h@%0d, required 0 %h@%0d",
                     name, imem_we, imem_wdata, imem_addr, exp_words[n-1], n - 1);
         end
      end
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err} !==
          {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL %s: got rdy=%b we=%b addr=%0d wdata=%h cpu_reset=%b busy=%b done=%b err=%b, required 1 0 0 0 1 0 0 0",
                  name, rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err);
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset_asserted");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_released");
   endtask

   task automatic test_directed_load();
      exp_words[0] = 32'hE3A00003;
      exp_words[1] = 32'hE3A01007;
      wr_q.delete();
      send_frame(2, 1'b1, 1'b0, 1'b1);
      check_load("directed_good", 2, 1'b1);
   endtask

   task automatic test_bad_checksum();
      exp_words[0] = 32'hE3A00003;
      exp_words[1] = 32'hE3A01007;
      wr_q.delete();
      send_frame(2, 1'b0, 1'b0, 1'b1);
      check_load("directed_bad_csum", 2, 1'b0);
   endtask

   task automatic test_len_over();
      wr_q.delete();
      send_byte(8'hA5, 0);
      send_byte(8'h41, 0);
      send_byte(8'h00, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      rx_valid = 1'b0;
      check_load("len_65", 0, 1'b0);
   endtask

   task automatic test_len_zero();
      wr_q.delete();
      send_frame(0, 1'b1, 1'b0, 1'b1);
      check_load("len_0", 0, 1'b1);
   endtask

   task automatic test_full_depth();
      for (int i = 0; i < DEPTH; i++) exp_words[i] = $urandom;
      wr_q.delete();
      send_frame(DEPTH, 1'b1, 1'b1, 1'b1);
      check_load("len_depth", DEPTH, 1'b1);
   endtask

   task automatic test_noise_and_run_drop();
      for (int i = 0; i < 3; i++) exp_words[i] = $urandom;
      wr_q.delete();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      send_frame(3, 1'b1, 1'b0, 1'b1);
      send_byte(noise_byte(), 0);
      send_byte(noise_byte(), 1);
      rx_valid = 1'b0;
      check_load("noise_then_run", 3, 1'b1);
   endtask

   task automatic test_reload();
      exp_words[0] = $urandom;
      send_byte(8'hA5, 0);
      checks++;
      if ({cpu_reset, done, busy} !== 3'b101) begin
         errors++;
         $display("FAIL reload_entry: got cpu_reset=%b done=%b busy=%b, required 1 0 1",
                  cpu_reset, done, busy);
      end
      wr_q.delete();
      send_frame(1, 1'b1, 1'b0, 1'b0);
      check_load("reload", 1, 1'b1);
   endtask

   task automatic test_reset_mid_data();
      exp_words[0] = 32'hDEADBEEF;
      send_byte(8'hA5, 0);
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      send_byte(8'h77, 0);
      send_byte(8'h88, 0);
      #2 reset = 1'b1;
      #1 check_idle_outputs("reset_mid_data");
      rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      wr_q.delete();
      send_frame(1, 1'b1, 1'b0, 1'b1);
      check_load("after_mid_reset", 1, 1'b1);
   endtask

   task automatic test_random_loads();
      int n;
      bit good;
      string name;
      for (int it = 0; it < 12; it++) begin
         n    = (it % 4 == 0) ? 0 : int'($urandom_range(1, 8));
         good = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) exp_words[i] = $urandom;
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) send_byte(noise_byte(), 0);
         wr_q.delete();
         send_frame(n, good, 1'b1, 1'b1);
         name = $sformatf("random_%0d", it);
         check_load(name, n, good);
      end
   endtask

   task automatic test_ready_rule();
      checks++;
      if (ready_viol !== 0) begin
         errors++;
         $display("FAIL ready_vs_write: %0d cycles with rx_ready==imem_we, required 0", ready_viol);
      end
   endtask

   initial begin
      test_reset();
      test_directed_load();
      test_bad_checksum();
      test_len_over();
      test_len_zero();
      test_full_depth();
      test_noise_and_run_drop();
      test_reload();
      test_reset_mid_data();
      test_random_loads();
      test_ready_rule();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
